// File: rtl/msp_int_block.sv
// Interrupt controller: latches rising edges on two external and two timer lines and
// issues one registered request pulse at a time, gated by GIE, until the sequencer returns.
module msp_int_block #(
  parameter logic [15:0] VEC_IRQ0 = 16'h1FF8,
  parameter logic [15:0] VEC_IRQ1 = 16'h1FFA,
  parameter logic [15:0] VEC_IRT1 = 16'h1FFC,
  parameter logic [15:0] VEC_IRT0 = 16'h1FFE
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  IRQ,
  input  logic [1:0]  IRT,
  input  logic        RTI,
  input  logic [15:0] SR,
  output logic        REQ,
  output logic [15:0] ADDRInt
);

  // Sources packed in priority order: bit 0 is the highest priority.
  logic [3:0]  src;
  logic [3:0]  prev_q, prev_d;
  logic [3:0]  pending_q, pending_d;
  logic        in_service_q, in_service_d;
  logic        req_q, req_d;
  logic [15:0] addr_q, addr_d;
  logic [3:0]  rise;
  logic [3:0]  winner;
  logic [15:0] win_vec;
  logic        grant;
  logic        unused_sr;

  assign src       = {IRT[0], IRT[1], IRQ[1], IRQ[0]};
  assign rise      = src & ~prev_q;
  assign unused_sr = ^{SR[15:4], SR[2:0]};

  always_comb begin
    winner  = 4'b0000;
    win_vec = addr_q;
    if (pending_q[0]) begin
      winner  = 4'b0001;
      win_vec = VEC_IRQ0;
    end else if (pending_q[1]) begin
      winner  = 4'b0010;
      win_vec = VEC_IRQ1;
    end else if (pending_q[2]) begin
      winner  = 4'b0100;
      win_vec = VEC_IRT1;
    end else if (pending_q[3]) begin
      winner  = 4'b1000;
      win_vec = VEC_IRT0;
    end
  end

  always_comb begin
    grant        = SR[3] & ~in_service_q & (|pending_q);
    prev_d       = src;
    req_d        = grant;
    addr_d       = grant ? win_vec : addr_q;
    // A fresh edge on the granted source re-arms it: set beats clear.
    pending_d    = (pending_q & ~(grant ? winner : 4'b0000)) | rise;
    in_service_d = in_service_q;
    if (grant) begin
      in_service_d = 1'b1;
    end else if (RTI) begin
      in_service_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      // Prev resets high so a line already high at release does not fire.
      prev_q       <= 4'b1111;
      pending_q    <= 4'b0000;
      in_service_q <= 1'b0;
      req_q        <= 1'b0;
      addr_q       <= 16'h0000;
    end else begin
      prev_q       <= prev_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
    end
  end

  assign REQ     = req_q;
  assign ADDRInt = addr_q;

endmodule

// File: tb/tb_msp_int_block.sv
// Self-checking bench for msp_int_block: directed scenarios plus random traffic, all compared
// against a behavioural model of pending requests and service state.
module tb_msp_int_block;

  logic        clk;
  logic        rst_n;
  logic [1:0]  irq;
  logic [1:0]  irt;
  logic        rti;
  logic [15:0] sr;
  logic        req;
  logic [15:0] addr;

  int checks = 0;
  int errors = 0;

  // Reference model state. Sources in priority order: IRQ0, IRQ1, IRT1, IRT0.
  logic [15:0] vec_tab [4] = '{16'h1FF8, 16'h1FFA, 16'h1FFC, 16'h1FFE};
  bit          m_pend [4];
  bit          m_prev [4];
  bit          m_busy;
  bit          m_req;
  logic [15:0] m_addr;

  msp_int_block dut (
    .CLK     (clk),
    .RESET   (rst_n),
    .IRQ     (irq),
    .IRT     (irt),
    .RTI     (rti),
    .SR      (sr),
    .REQ     (req),
    .ADDRInt (addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit lvl [4];
    bit granted;
    lvl[0] = irq[0]; lvl[1] = irq[1]; lvl[2] = irt[1]; lvl[3] = irt[0];
    if (!rst_n) begin
      m_req  = 0;
      m_addr = 16'h0000;
      m_busy = 0;
      foreach (m_pend[i]) begin
        m_pend[i] = 0;
        m_prev[i] = 1;
      end
      return;
    end
    m_req   = 0;
    granted = 0;
    if (sr[3] && !m_busy) begin
      for (int i = 0; i < 4; i++) begin
        if (!granted && m_pend[i]) begin
          granted   = 1;
          m_req     = 1;
          m_addr    = vec_tab[i];
          m_pend[i] = 0;
          m_busy    = 1;
        end
      end
    end
    if (!granted && rti) m_busy = 0;
    for (int i = 0; i < 4; i++) begin
      if (lvl[i] && !m_prev[i]) m_pend[i] = 1;
      m_prev[i] = lvl[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_req", {15'd0, req}, {15'd0, m_req});
    check("model_addr", addr, m_addr);
  endtask

  task automatic expect_req(input string tag, input logic [15:0] vec);
    check({tag, "_req"}, {15'd0, req}, 16'd1);
    check({tag, "_addr"}, addr, vec);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_noreq"}, {15'd0, req}, 16'd0);
  endtask

  initial begin
    rst_n = 0; irq = 2'b11; irt = 2'b00; rti = 0; sr = 16'h0008;
    #1;
    // Reset with requests held high
    tick(); tick();
    expect_idle("reset");
    check("reset_addr", addr, 16'h0000);
    rst_n = 1;
    repeat (3) begin
      tick();
      expect_idle("release_high");
    end
    irq = 2'b01; tick();
    irq = 2'b11; tick();
    expect_idle("edge_cycle");
    tick();
    expect_req("irq1_after_reset", 16'h1FFA);
    tick();
    expect_idle("req_one_cycle");
    // New IRQ1 edges while in service wait for RTI
    irq = 2'b01; tick();
    irq = 2'b11; tick(); tick(); tick();
    expect_idle("busy_block");
    rti = 1; tick();
    rti = 0; tick();
    expect_req("after_rti", 16'h1FFA);
    rti = 1; tick();
    rti = 0; irq = 2'b00; tick(); tick();

    // Both timers together: IRT1 first, then IRT0
    irt = 2'b11; tick();
    irt = 2'b00; tick();
    expect_req("irt1_first", 16'h1FFC);
    tick();
    rti = 1; tick();
    rti = 0; tick();
    expect_req("irt0_second", 16'h1FFE);
    repeat (3) begin
      tick();
      expect_idle("irt_drained");
    end
    rti = 1; tick();
    rti = 0;

    // GIE low accumulates, grant on re-enable
    sr = 16'h0000;
    irq = 2'b01; irt = 2'b01; tick();
    irq = 2'b00; irt = 2'b00;
    repeat (10) begin
      tick();
      expect_idle("gie_off");
    end
    sr = 16'h0008; tick();
    expect_req("gie_on", 16'h1FF8);
    tick();
    rti = 1; tick();
    rti = 0; tick();
    expect_req("gie_second", 16'h1FFE);

    // No nesting; RTI coincident with a fresh edge
    irq = 2'b01; tick();
    irq = 2'b00; tick();
    expect_idle("no_nest");
    irq = 2'b10; rti = 1; tick();
    irq = 2'b00; rti = 0; tick();
    expect_req("prio_irq0", 16'h1FF8);
    tick();
    rti = 1; tick();
    rti = 0; tick();
    expect_req("then_irq1", 16'h1FFA);
    rti = 1; tick();
    rti = 0; tick();

    // Reset drops pending requests
    sr = 16'h0000;
    irq = 2'b10; tick();
    irq = 2'b00; tick();
    rst_n = 0; tick();
    rst_n = 1; sr = 16'h0008;
    repeat (4) begin
      tick();
      expect_idle("reset_clears");
    end

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      irq   = 2'($urandom_range(0, 3));
      irt   = 2'($urandom_range(0, 3));
      rti   = ($urandom_range(0, 3) == 0);
      sr    = 16'($urandom) & 16'hFFF7;
      sr[3] = ($urandom_range(0, 4) != 0);
      rst_n = ($urandom_range(0, 60) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
